// File: rtl/cnt_sched.sv
// cnt_sched: two-requester round-robin scheduler driving a shared counter.
//
// A requester holds its req bit high and, once granted, owns the counter.
// The counter runs from 0 up to the length that requester supplied at grant
// time. Completion gives a single done pulse. If the owner drops its request
// early, the operation is abandoned without a done pulse.
//
// Ports:
//   clk   - clock, rising edge active
//   rst   - asynchronous reset, active low
//   req   - per-requester request bits
//   len0  - terminal count for requester 0, latched at grant
//   len1  - terminal count for requester 1, latched at grant
//   en    - count enable; low pauses the count while running
//   gnt   - one-hot grant, high for the owner's whole RUN phase
//   cnt   - shared counter value
//   busy  - high while an operation is running or completing
//   done  - one-cycle completion pulse for the owner
module cnt_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             en,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic [1:0]       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateType;

  stateType         state;
  stateType         stateNext;
  logic             ptr;
  logic             ptrNext;
  logic             owner;
  logic             ownerNext;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] limitNext;
  logic [WIDTH-1:0] cntNext;
  logic [1:0]       gntNext;
  logic [1:0]       doneNext;
  logic             winner;

  // With a single requester, that requester wins.
  // With both requesting, the round-robin pointer decides.
  assign winner = (req == 2'b11) ? ptr : req[1];

  // Busy covers both the counting phase and the completion cycle.
  assign busy = (state != IDLE);

  // Next-state and next-output logic.
  // Every register defaults to holding its value, except done, which is
  // a pulse and therefore defaults to zero.
  always_comb begin
    stateNext = state;
    ptrNext   = ptr;
    ownerNext = owner;
    limitNext = limit;
    cntNext   = cnt;
    gntNext   = gnt;
    doneNext  = 2'b00;
    case (state)
      IDLE: begin
        gntNext = 2'b00;
        if (req != 2'b00) begin
          ownerNext = winner;
          limitNext = winner ? len1 : len0;
          cntNext   = '0;
          gntNext   = winner ? 2'b10 : 2'b01;
          stateNext = RUN;
        end
      end
      RUN: begin
        // Abort wins over counting: the owner withdrew its request.
        if (!req[owner]) begin
          stateNext = IDLE;
          gntNext   = 2'b00;
          ptrNext   = ~owner;
        end else if (en) begin
          if (cnt == limit) begin
            stateNext       = DONE;
            gntNext         = 2'b00;
            doneNext[owner] = 1'b1;
            ptrNext         = ~owner;
          end else begin
            cntNext = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        gntNext   = 2'b00;
      end
    endcase
  end

  // State and output registers.
  // Reset is asynchronous and active low, and it clears the scheduler
  // back to an idle state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      limit <= '0;
      cnt   <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
    end else begin
      state <= stateNext;
      ptr   <= ptrNext;
      owner <= ownerNext;
      limit <= limitNext;
      cnt   <= cntNext;
      gnt   <= gntNext;
      done  <= doneNext;
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: directed self-checking bench for cnt_sched (WIDTH = 4).
// Inputs change on the falling edge and outputs are sampled there too,
// half a cycle away from the active rising edge.
module tb_cnt_sched;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       en;
  logic [1:0] gnt;
  logic [3:0] cnt;
  logic       busy;
  logic [1:0] done;

  int passCount = 0;
  int totalCount = 0;

  cnt_sched #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len0 (len0),
    .len1 (len1),
    .en   (en),
    .gnt  (gnt),
    .cnt  (cnt),
    .busy (busy),
    .done (done)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle: through a rising edge, then to the next falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare every output against the expected values as one check.
  task automatic checkOutput(input string tag, input logic [1:0] expGnt,
                             input logic [3:0] expCnt, input logic expBusy,
                             input logic [1:0] expDone);
    totalCount++;
    assert ({gnt, cnt, busy, done} === {expGnt, expCnt, expBusy, expDone})
      passCount++;
    else
      $error("[TB] FAIL %s: got gnt=%b cnt=%0d busy=%b done=%b, expected gnt=%b cnt=%0d busy=%b done=%b",
             tag, gnt, cnt, busy, done, expGnt, expCnt, expBusy, expDone);
  endtask

  initial begin
    rst  = 1'b0;
    req  = 2'b00;
    len0 = 4'd0;
    len1 = 4'd0;
    en   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 2'b00, 4'd0, 1'b0, 2'b00);
    rst = 1'b1;

    // Single request, len0 = 3.
    req  = 2'b01;
    len0 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput($sformatf("single_run%0d", i), 2'b01, 4'(i), 1'b1, 2'b00);
    end
    applyStimulus();
    checkOutput("single_done", 2'b00, 4'd3, 1'b1, 2'b01);
    req = 2'b00;
    applyStimulus();
    checkOutput("single_idle", 2'b00, 4'd3, 1'b0, 2'b00);

    // Asynchronous reset from idle. The pointer is now 1; reset must clear it.
    rst = 1'b0;
    #1;
    checkOutput("async_reset_idle", 2'b00, 4'd0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b1;

    // Contention from reset: requester 0 first, then requester 1.
    req  = 2'b11;
    len0 = 4'd1;
    len1 = 4'd2;
    applyStimulus();
    checkOutput("cont_r0_run0", 2'b01, 4'd0, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("cont_r0_run1", 2'b01, 4'd1, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("cont_r0_done", 2'b00, 4'd1, 1'b1, 2'b01);
    req = 2'b10;
    applyStimulus();
    checkOutput("cont_gap_idle", 2'b00, 4'd1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("cont_r1_run%0d", i), 2'b10, 4'(i), 1'b1, 2'b00);
    end
    applyStimulus();
    checkOutput("cont_r1_done", 2'b00, 4'd2, 1'b1, 2'b10);

    // Second round with both requesting: the pointer now favours requester 0.
    req  = 2'b11;
    len0 = 4'd5;
    applyStimulus();
    checkOutput("round2_idle", 2'b00, 4'd2, 1'b0, 2'b00);
    applyStimulus();
    checkOutput("round2_r0_run0", 2'b01, 4'd0, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("round2_r0_run1", 2'b01, 4'd1, 1'b1, 2'b00);
    // A length change during RUN must not shorten the operation.
    len0 = 4'd0;
    applyStimulus();
    checkOutput("round2_r0_run2", 2'b01, 4'd2, 1'b1, 2'b00);

    // Abort: requester 0 withdraws while cnt = 2.
    req = 2'b10;
    applyStimulus();
    checkOutput("abort_idle", 2'b00, 4'd2, 1'b0, 2'b00);
    applyStimulus();
    checkOutput("abort_r1_grant", 2'b10, 4'd0, 1'b1, 2'b00);
    applyStimulus();
    applyStimulus();
    checkOutput("abort_r1_run2", 2'b10, 4'd2, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("abort_r1_done", 2'b00, 4'd2, 1'b1, 2'b10);
    req = 2'b00;
    applyStimulus();

    // Zero length on requester 1: a single RUN cycle.
    req  = 2'b10;
    len1 = 4'd0;
    applyStimulus();
    checkOutput("zero_run", 2'b10, 4'd0, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("zero_done", 2'b00, 4'd0, 1'b1, 2'b10);
    req = 2'b00;
    applyStimulus();
    checkOutput("zero_idle", 2'b00, 4'd0, 1'b0, 2'b00);

    // Maximum length on requester 1: cnt reaches 15 and stops there.
    req  = 2'b10;
    len1 = 4'd15;
    applyStimulus();
    checkOutput("max_run0", 2'b10, 4'd0, 1'b1, 2'b00);
    len1 = 4'd3;
    for (int i = 1; i < 16; i++) begin
      applyStimulus();
      checkOutput($sformatf("max_run%0d", i), 2'b10, 4'(i), 1'b1, 2'b00);
    end
    applyStimulus();
    checkOutput("max_done", 2'b00, 4'd15, 1'b1, 2'b10);
    req = 2'b00;
    applyStimulus();
    checkOutput("max_idle", 2'b00, 4'd15, 1'b0, 2'b00);

    // Pause: len0 = 2, en held low for three cycles once cnt = 1.
    req  = 2'b01;
    len0 = 4'd2;
    applyStimulus();
    checkOutput("pause_run0", 2'b01, 4'd0, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("pause_run1", 2'b01, 4'd1, 1'b1, 2'b00);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("pause_hold%0d", i), 2'b01, 4'd1, 1'b1, 2'b00);
    end
    en = 1'b1;
    applyStimulus();
    checkOutput("pause_run2", 2'b01, 4'd2, 1'b1, 2'b00);
    applyStimulus();
    checkOutput("pause_done", 2'b00, 4'd2, 1'b1, 2'b01);
    req = 2'b00;
    applyStimulus();
    checkOutput("pause_idle", 2'b00, 4'd2, 1'b0, 2'b00);

    // Reset mid-RUN. The pointer is 1 here, so the post-reset grant
    // shows whether reset restored it to 0.
    req  = 2'b10;
    len1 = 4'd9;
    for (int i = 0; i < 6; i++) applyStimulus();
    checkOutput("midrun_cnt5", 2'b10, 4'd5, 1'b1, 2'b00);
    rst = 1'b0;
    #1;
    checkOutput("midrun_async_reset", 2'b00, 4'd0, 1'b0, 2'b00);
    req  = 2'b11;
    len0 = 4'd1;
    @(negedge clk);
    checkOutput("midrun_held_reset", 2'b00, 4'd0, 1'b0, 2'b00);
    rst = 1'b1;
    applyStimulus();
    checkOutput("post_reset_grant", 2'b01, 4'd0, 1'b1, 2'b00);
    applyStimulus();
    applyStimulus();
    checkOutput("post_reset_done", 2'b00, 4'd1, 1'b1, 2'b01);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/cnt_sched.md
CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, which sets the counter and length width in bits.
REQ-002 The module SHALL have port clk  input  1  clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-004 The module SHALL have port req  input  2  per-requester request; bit i is held high by requester i until done[i] or until it abandons the request.
REQ-005 The module SHALL have port len0  input  WIDTH  terminal count for requester 0; sampled only at grant.
REQ-006 The module SHALL have port len1  input  WIDTH  terminal count for requester 1; sampled only at grant.
REQ-007 The module SHALL have port en  input  1  count enable; low pauses counting in RUN.
REQ-008 The module SHALL have port gnt  output  2  one-hot grant, registered; high for the whole RUN state of the owner.
REQ-009 The module SHALL have port cnt  output  WIDTH  shared counter value, registered.
REQ-010 The module SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 The module SHALL have port done  output  2  one-cycle completion pulse for the owner, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, at a rising edge with req!=0, the module SHALL select a winner, latch the winner's len into an internal limit, set cnt=0, assert gnt[winner], and enter RUN.
REQ-014 Arbitration SHALL be round-robin: a 1-bit pointer names the priority requester, and when both request, the pointer's requester wins.
REQ-015 The pointer SHALL be set to the non-owner on every exit from RUN, whether by completion or by abort.
REQ-016 In RUN with en=1: if cnt==limit, the module SHALL enter DONE; otherwise cnt SHALL become cnt+1.
REQ-017 In RUN with en=0: cnt, gnt and the state SHALL hold.
REQ-018 RUN SHALL therefore last limit+1 enabled cycles; len=0 SHALL give exactly one RUN cycle with cnt=0.
REQ-019 cnt SHALL never wrap, because limit is at most 2^WIDTH-1 and counting stops at limit.
REQ-020 In DONE (one cycle): done[owner]=1, gnt=0, busy=1, and cnt SHALL hold limit; the next edge SHALL enter IDLE.
REQ-021 In IDLE: done=0, gnt=0, busy=0, and cnt SHALL hold its last value.
REQ-022 Abort: if req[owner]=0 at an edge in RUN, the module SHALL enter IDLE at that edge with no done pulse and gnt cleared; abort SHALL take priority over the en/terminal-count check.
REQ-023 For back-to-back requests, the minimum gap SHALL be one IDLE cycle between DONE and the next RUN.
REQ-024 Changes on len0/len1 during RUN SHALL have no effect on the current operation.
REQ-025 A request from the non-owner during RUN SHALL be ignored until IDLE, and SHALL then be served (pointer favours it).
REQ-026 gnt and done SHALL always be one-hot or zero, and never both nonzero in the same cycle.

Reset
REQ-027 On rst=0, the module SHALL immediately enter IDLE, with pointer=0, limit=0, cnt=0, gnt=0, done=0 and busy=0, regardless of clk.
REQ-028 Reset mid-RUN SHALL discard the operation with no done pulse; the first grant after release SHALL follow REQ-013 with pointer=0.

Verification
REQ-029 Single request: req=01, len0=3, en=1 -> gnt=01 for 4 cycles with cnt 0,1,2,3; then done=01 for 1 cycle; then IDLE with cnt=3.
REQ-030 Contention: req=11 from reset, len0=1, len1=2 -> requester 0 is served first (2 RUN cycles), then one IDLE cycle, then gnt=10 for 3 RUN cycles and done=10; a second round starts with requester 0.
REQ-031 Pause: len0=2, en low for 3 cycles after cnt=1 -> cnt holds 1, gnt holds 01, and total RUN is 6 cycles.
REQ-032 Zero and maximum length: len1=0 -> 1 RUN cycle (cnt=0), then done=10; len1=15 -> cnt reaches 15 with no wrap, then done.
REQ-033 Abort: req0 drops while cnt=2 -> IDLE at the next edge, done stays 0, and a pending req1 is granted on the following edge.
REQ-034 Reset mid-RUN: rst=0 while cnt=5 -> cnt=0, gnt=0, busy=0 asynchronously; after release with req=11, requester 0 wins.
